// File: rtl/inst_encoder.sv
// RV32I field packer for the debug monitor: assembles one instruction
// word, range-checks it, and writes it to instruction memory.
module inst_encoder #(
    parameter int IADR_W   = 14,
    parameter int BASE_ADR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enc_req,
    input  logic [2:0]        enc_fmt,
    input  logic [6:0]        enc_opcode,
    input  logic [2:0]        enc_funct3,
    input  logic [6:0]        enc_funct7,
    input  logic [4:0]        enc_rd,
    input  logic [4:0]        enc_rs1,
    input  logic [4:0]        enc_rs2,
    input  logic [31:0]       enc_imm,
    input  logic              enc_adr_set,
    input  logic [IADR_W-1:0] enc_adr,
    output logic              enc_busy,
    output logic              enc_done,
    output logic              enc_err,
    output logic [31:0]       enc_inst,
    output logic [IADR_W-1:0] wr_adr,
    output logic              imem_we,
    output logic [IADR_W-1:0] imem_wadr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_wack
);

    localparam logic [IADR_W-1:0] BASE_A = IADR_W'(BASE_ADR);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WRITE,
        DONE
    } state_t;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } fields_t;

    state_t            state_q, state_d;
    fields_t           fld_q, fld_d;
    logic [IADR_W-1:0] wr_adr_q, wr_adr_d;
    logic [31:0]       inst_q, inst_d;

    logic [31:0] word;
    logic        bad;
    logic        imm12_ok;
    logic        imm13_ok;
    logic        imm21_ok;

    // Sign-extension checks: upper bits must all match the top legal bit.
    assign imm12_ok = (&fld_q.imm[31:11]) || (~|fld_q.imm[31:11]);
    assign imm13_ok = (&fld_q.imm[31:12]) || (~|fld_q.imm[31:12]);
    assign imm21_ok = (&fld_q.imm[31:20]) || (~|fld_q.imm[31:20]);

    always_comb begin
        word = '0;
        bad  = 1'b0;
        unique case (fld_q.fmt)
            3'd0: begin
                word = {fld_q.f7, fld_q.rs2, fld_q.rs1,
                        fld_q.f3, fld_q.rd, fld_q.op};
            end
            3'd1: begin
                word = {fld_q.imm[11:0], fld_q.rs1,
                        fld_q.f3, fld_q.rd, fld_q.op};
                bad  = !imm12_ok;
            end
            3'd2: begin
                word = {fld_q.imm[11:5], fld_q.rs2, fld_q.rs1,
                        fld_q.f3, fld_q.imm[4:0], fld_q.op};
                bad  = !imm12_ok;
            end
            3'd3: begin
                word = {fld_q.imm[12], fld_q.imm[10:5],
                        fld_q.rs2, fld_q.rs1, fld_q.f3,
                        fld_q.imm[4:1], fld_q.imm[11], fld_q.op};
                bad  = !imm13_ok || fld_q.imm[0];
            end
            3'd4: begin
                word = {fld_q.imm[31:12], fld_q.rd, fld_q.op};
                bad  = |fld_q.imm[11:0];
            end
            3'd5: begin
                word = {fld_q.imm[20], fld_q.imm[10:1],
                        fld_q.imm[11], fld_q.imm[19:12],
                        fld_q.rd, fld_q.op};
                bad  = !imm21_ok || fld_q.imm[0];
            end
            default: begin
                bad = 1'b1;
            end
        endcase
        if (fld_q.op[1:0] != 2'b11) begin
            bad = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        fld_d    = fld_q;
        wr_adr_d = wr_adr_q;
        inst_d   = inst_q;
        unique case (state_q)
            IDLE: begin
                if (enc_adr_set) begin
                    wr_adr_d = enc_adr;
                end
                if (enc_req) begin
                    fld_d = '{enc_fmt, enc_opcode, enc_funct3,
                              enc_funct7, enc_rd, enc_rs1,
                              enc_rs2, enc_imm};
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (bad) begin
                    state_d = IDLE;
                end else begin
                    inst_d  = word;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (imem_wack) begin
                    wr_adr_d = wr_adr_q + 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            fld_q    <= '0;
            wr_adr_q <= BASE_A;
            inst_q   <= '0;
        end else begin
            state_q  <= state_d;
            fld_q    <= fld_d;
            wr_adr_q <= wr_adr_d;
            inst_q   <= inst_d;
        end
    end

    assign enc_busy   = (state_q != IDLE);
    assign enc_done   = (state_q == DONE);
    assign enc_err    = (state_q == CHECK) && bad;
    assign enc_inst   = inst_q;
    assign wr_adr     = wr_adr_q;
    assign imem_we    = (state_q == WRITE);
    assign imem_wadr  = wr_adr_q;
    assign imem_wdata = inst_q;

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Inverse of the ID-stage instruction decoder: packs RV32I instruction fields (format, opcode, funct3/funct7, rd/rs1/rs2, immediate) into a 32-bit instruction word.
- Range-checks the fields, then writes the word into instruction memory through a ready/ack write port.
- Used by the debug monitor to patch or assemble code in place.
- Keeps an auto-incrementing word write address.

Parameters:
IADR_W, 14, instruction-memory word-address width
BASE_ADR, 0, write address loaded at reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
enc_req  in  1  start encode/write; sampled only in IDLE
enc_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
enc_opcode  in  7  opcode, bits [6:0]
enc_funct3  in  3  funct3
enc_funct7  in  7  funct7 (R only)
enc_rd  in  5  destination register
enc_rs1  in  5  source register 1
enc_rs2  in  5  source register 2
enc_imm  in  32  signed immediate; byte offset for B/J; full value for U
enc_adr_set  in  1  load write address (IDLE only)
enc_adr  in  IADR_W  address value for enc_adr_set
enc_busy  out  1  high in any state other than IDLE
enc_done  out  1  one-cycle pulse: word written
enc_err  out  1  one-cycle pulse: request rejected
enc_inst  out  32  last encoded word, held until next encode
wr_adr  out  IADR_W  current write address
imem_we  out  1  write request, held until ack
imem_wadr  out  IADR_W  write address
imem_wdata  out  32  write data
imem_wack  in  1  memory accepted write

Behaviour:
- Reset values: all outputs 0 except wr_adr=BASE_ADR; FSM goes to IDLE. Reset asserted mid-operation drops imem_we immediately and discards the request.
- FSM states: IDLE, CHECK, WRITE, DONE.
- IDLE:
  - enc_adr_set loads wr_adr<=enc_adr.
  - enc_req registers all input fields and moves to CHECK.
  - If enc_adr_set and enc_req are both high, the address is loaded first; the write uses the new address.
  - enc_req and enc_adr_set are ignored in every other state.
- CHECK (one cycle): encode the word and validate. On error: pulse enc_err, go to IDLE, wr_adr and enc_inst unchanged, no write. Otherwise enc_inst<=word and go to WRITE.
- Encodings, MSB to LSB:
  - R: f7|rs2|rs1|f3|rd|op
  - I: imm[11:0]|rs1|f3|rd|op
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
  - U: imm[31:12]|rd|op
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
- Error conditions:
  - enc_fmt is 6 or 7.
  - enc_opcode[1:0]!=2'b11 (compressed encodings not supported).
  - I/S: imm outside [-2048, 2047].
  - B: imm outside [-4096, 4094], or imm[0]=1.
  - J: imm outside [-1048576, 1048574], or imm[0]=1.
  - U: imm[11:0]!=0.
  - R: imm is ignored; unused register fields are ignored in all formats.
- WRITE:
  - imem_we=1; imem_wadr=wr_adr; imem_wdata=enc_inst. All three stay stable until the cycle imem_wack=1.
  - On ack: wr_adr<=wr_adr+1 modulo 2^IADR_W (all-ones wraps to 0), then go to DONE.
  - imem_wack outside WRITE is ignored.
- DONE: enc_done=1 for one cycle, then IDLE.
- Latency: enc_req seen at cycle N gives imem_we high from N+2. With zero-wait ack at N+2, enc_done pulses at N+3 and a new request is accepted at N+4.

Test Plan:
- addi x1,x0,5 (fmt=1, op=0x13, f3=0, rd=1, rs1=0, imm=5), wr_adr=0, immediate ack -> imem_wdata=0x00500093 at imem_wadr 0; enc_done one cycle; wr_adr=1.
- nop (fmt=1, op=0x13, all fields 0), ack delayed 3 cycles -> imem_we held 3 cycles with data 0x00000013 stable; a second enc_req during WRITE is ignored (exactly one write).
- beq x1,x2,-4 (fmt=3, op=0x63, rs1=1, rs2=2, imm=-4) -> 0xFE208EE3. jal x1,+2048 (fmt=5, op=0x6F, rd=1, imm=0x800) -> 0x001000EF. lui x5,0x12345000 (fmt=4, op=0x37, rd=5) -> 0x123452B7.
- Rejects: I with imm=2048; B with imm=3; fmt=7; op=0x10; U with imm=0x1 -> each gives an enc_err pulse in CHECK, no imem_we, wr_adr and enc_inst unchanged.
- enc_adr_set=1 with enc_adr=2^IADR_W-1 and enc_req in the same cycle -> write lands at the all-ones address; afterwards wr_adr=0.
- rst asserted while in WRITE with no ack -> imem_we=0 immediately (asynchronous), wr_adr=BASE_ADR, enc_busy=0; after release the next request behaves normally.
